uart_alu_ctrl: RTL and testbench

Frame controller between the UART receiver, the ALU and the UART transmitter. It collects a three-byte command frame from the receiver: operand A, then operand B, then opcode. It holds these as registered ALU inputs, captures the ALU result and launches it on the transmitter. It then waits for transmit completion before accepting the next frame. An inter-byte timeout resynchronises framing, and a saturating counter reports bytes dropped while busy.

---
 rtl/uart_alu_ctrl_pkg.sv | 34 +++
 rtl/uart_alu_ctrl_frame_timeout.sv | 39 +++
 rtl/uart_alu_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_ctrl_pkg.sv
// Shared definitions for the UART/ALU frame controller.
//   - state encodings (3-bit) and the FSM state enum
//   - command frame byte order
//   - drop counter width, saturation value and saturating increment helper
package uart_alu_ctrl_pkg;

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;

  typedef enum logic [2:0] {
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_e;

  // Frame byte order on the receive side: operand A, operand B, opcode.
  localparam int FRAME_IDX_A  = 0;
  localparam int FRAME_IDX_B  = 1;
  localparam int FRAME_IDX_OP = 2;
  localparam int FRAME_BYTES  = 3;

  localparam int                  DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_frame_timeout.sv
// frame_timeout: inter-byte watchdog.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clr         - restart the count from zero
//   en          - count this cycle (only while waiting for a frame byte)
//   expired     - count has reached TO_CYCLES-1 while enabled
// TO_CYCLES = 0 disables the watchdog entirely.
module frame_timeout #(
  parameter int TO_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TO_CYCLES > 0) ? CNT_W'(TO_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Holds at CNT_LAST; the owner leaves the waiting state on expiry anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != CNT_LAST))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = (TO_CYCLES > 0) && en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects an A / B / opcode frame from the UART receiver,
// presents it as registered ALU inputs, launches the ALU result on the
// transmitter and waits for transmit completion.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   rx_done_tick, rx_data      - received byte strobe and data
//   alu_result                 - combinational ALU output
//   tx_done_tick               - transmitter finished its byte
//   alu_a, alu_b, alu_op       - registered ALU inputs
//   tx_start, tx_data          - one-cycle launch pulse and result byte
//   busy                       - high in SEND and WAIT_TX
//   drop_cnt                   - saturating count of bytes dropped while busy
//
// state   | meaning
// --------+-----------------------------------------------
// WAIT_A  | idle, next byte is operand A
// WAIT_B  | next byte is operand B (timeout armed)
// WAIT_OP | next byte is opcode (timeout armed)
// SEND    | latch ALU result, raise tx_start next cycle
// WAIT_TX | transmitting, wait for tx_done_tick
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int DBIT      = 8,
  parameter int NB_OP     = 6,
  parameter int TO_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [DBIT-1:0]       rx_data,
  input  logic [DBIT-1:0]       alu_result,
  input  logic                  tx_done_tick,
  output logic [DBIT-1:0]       alu_a,
  output logic [DBIT-1:0]       alu_b,
  output logic [NB_OP-1:0]      alu_op,
  output logic                  tx_start,
  output logic [DBIT-1:0]       tx_data,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  state_e                  state_q, state_d;
  logic [DBIT-1:0]         alu_a_q, alu_a_d;
  logic [DBIT-1:0]         alu_b_q, alu_b_d;
  logic [NB_OP-1:0]        alu_op_q, alu_op_d;
  logic [DBIT-1:0]         tx_data_q, tx_data_d;
  logic                    tx_start_q, tx_start_d;
  logic                    busy_q, busy_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                    accept;
  logic                    to_en;
  logic                    to_expired;

  assign to_en = (state_q == WAIT_B) || (state_q == WAIT_OP);

  frame_timeout #(.TO_CYCLES(TO_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (to_en),
    .expired (to_expired)
  );

  // A byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    drop_cnt_d = drop_cnt_q;
    accept     = 1'b0;
    unique case (state_q)
      WAIT_A: begin
        if (rx_done_tick) begin
          alu_a_d = rx_data;
          accept  = 1'b1;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_done_tick) begin
          alu_b_d = rx_data;
          accept  = 1'b1;
          state_d = WAIT_OP;
        end else if (to_expired) begin
          state_d = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (rx_done_tick) begin
          alu_op_d = rx_data[NB_OP-1:0];
          accept   = 1'b1;
          state_d  = SEND;
        end else if (to_expired) begin
          state_d = WAIT_A;
        end
      end
      SEND: begin
        tx_data_d = alu_result;
        state_d   = WAIT_TX;
        if (rx_done_tick) drop_cnt_d = drop_sat_inc(drop_cnt_q);
      end
      WAIT_TX: begin
        if (tx_done_tick) state_d = WAIT_A;
        if (rx_done_tick) drop_cnt_d = drop_sat_inc(drop_cnt_q);
      end
      default: state_d = WAIT_A;
    endcase
    tx_start_d = (state_q == SEND);
    busy_d     = (state_d == SEND) || (state_d == WAIT_TX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Testbench for uart_alu_ctrl with a small combinational ALU model.
// Stimulus updates a frame-level reference model and pushes the expected
// transmission into a scoreboard; a monitor pops it on every tx_start.
module tb_uart_alu_ctrl;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done_tick = 1'b0;
  logic [7:0] alu_result;
  logic [7:0] alu_a, alu_b, tx_data, drop_cnt;
  logic [5:0] alu_op;
  logic       tx_start, busy;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  uart_alu_ctrl #(.DBIT(8), .NB_OP(6), .TO_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .alu_result   (alu_result),
    .tx_done_tick (tx_done_tick),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model: bytes of the partial frame, time of last accepted byte.
  logic [7:0] m_frame[$];
  int         m_last_t = 0;
  bit         m_busy = 0;
  logic [7:0] m_a = 0, m_b = 0, m_tx = 0;
  logic [5:0] m_op = 0;
  int         m_drop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (tx_start === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_start_unexpected: tx_start=1 tx_data=%0h at cycle %0d, expected no tx_start", tx_data, cyc);
      end else begin
        e = sb.pop_front();
        chk("tx_start_cycle", cyc, e.cyc);
        chk("tx_data", tx_data, e.res);
        chk("tx_alu_a", alu_a, e.a);
        chk("tx_alu_b", alu_b, e.b);
        chk("tx_alu_op", alu_op, e.op);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_byte(input logic [7:0] b, input int t);
    if (m_busy) begin
      if (m_drop < 255) m_drop++;
    end else begin
      if (m_frame.size() > 0 && (t - m_last_t) > TO) m_frame.delete();
      m_frame.push_back(b);
      m_last_t = t;
      if (m_frame.size() == 1) m_a = b;
      else if (m_frame.size() == 2) m_b = b;
      else begin
        m_op = b[5:0];
        m_tx = alu_fn(m_a, m_b, m_op);
        sb.push_back('{m_a, m_b, m_op, m_tx, t + 1});
        m_busy = 1;
        m_frame.delete();
      end
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_alu_a"}, alu_a, m_a);
    chk({tag, "_alu_b"}, alu_b, m_b);
    chk({tag, "_alu_op"}, alu_op, m_op);
    chk({tag, "_drop_cnt"}, drop_cnt, m_drop);
    chk({tag, "_busy"}, busy, m_busy);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    rx_done_tick = 1'b1;
    rx_data = b;
    t = cyc + 1;
    model_byte(b, t);
    tick();
    rx_done_tick = 1'b0;
    check_state("byte");
  endtask

  task automatic wait_tx();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL tx_start_missing: no tx_start within 20 cycles, expected tx_data=%0h", sb[0].res);
      sb.delete();
    end
  endtask

  task automatic finish_tx(input int ndrop);
    wait_tx();
    for (int i = 0; i < ndrop; i++) begin
      idle($urandom_range(0, 2));
      send_byte($urandom_range(0, 255));
    end
    idle($urandom_range(0, 3));
    chk("busy_before_done", busy, 1);
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    m_busy = 0;
    chk("busy_after_done", busy, 0);
    chk("tx_data_hold", tx_data, m_tx);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_frame.delete();
    m_busy = 0;
    m_a = 0; m_b = 0; m_op = 0; m_tx = 0; m_drop = 0;
    sb.delete();
    check_state("reset");
    chk("reset_tx_data", tx_data, 0);
    chk("reset_tx_start", tx_start, 0);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] ops[6];
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27};
    if ($urandom_range(0, 1) == 1)
      return ops[$urandom_range(0, 5)] | (8'($urandom_range(0, 3)) << 6);
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    do_reset();

    // Basic add frame, drops while transmitting, next byte after done.
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    chk("frame0_alu_a", alu_a, 8'h05);
    chk("frame0_alu_b", alu_b, 8'h03);
    chk("frame0_alu_op", alu_op, 6'h20);
    chk("frame0_busy_send", busy, 1);
    wait_tx();
    chk("frame0_tx_data", tx_data, 8'h08);
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("drop_two", drop_cnt, 2);
    chk("busy_after_drops", busy, 1);
    finish_tx(0);
    send_byte(8'h11);
    chk("next_frame_alu_a", alu_a, 8'h11);
    send_byte(8'h02);
    send_byte(8'h22);
    finish_tx(1);

    // tx_done_tick outside WAIT_TX has no effect.
    tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
    check_state("stray_done_idle");
    send_byte(8'h33);
    tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
    check_state("stray_done_wait_b");
    send_byte(8'h44);
    send_byte(8'h26);
    finish_tx(0);
    chk("stray_done_tx", tx_data, 8'h77);

    // Timeout: 21 cycles between bytes abandons the partial frame.
    send_byte(8'h01);
    idle(TO);
    send_byte(8'h02);
    chk("timeout_realign_a", alu_a, 8'h02);
    send_byte(8'h03);
    send_byte(8'h20);
    finish_tx(0);
    chk("timeout_frame_tx", tx_data, 8'h05);

    // Byte on the exact timeout cycle is accepted.
    send_byte(8'h07);
    idle(TO - 1);
    send_byte(8'h09);
    chk("edge_alu_a", alu_a, 8'h07);
    chk("edge_alu_b", alu_b, 8'h09);
    idle(TO - 1);
    send_byte(8'h20);
    chk("edge_op_busy", busy, 1);
    finish_tx(0);
    chk("edge_tx", tx_data, 8'h10);

    // Reset in WAIT_OP, then in WAIT_TX; frames afterwards work.
    send_byte(8'h21);
    send_byte(8'h22);
    do_reset();
    idle(3);
    send_byte(8'h04);
    send_byte(8'h06);
    send_byte(8'h22);
    finish_tx(0);
    chk("post_reset_tx", tx_data, 8'hFE);
    send_byte(8'h10);
    send_byte(8'h01);
    send_byte(8'h20);
    wait_tx();
    do_reset();
    idle(3);
    send_byte(8'hF0);
    send_byte(8'h0F);
    send_byte(8'h25);
    finish_tx(0);
    chk("post_reset2_tx", tx_data, 8'hFF);

    // Randomised frames with random gaps (some exceed the timeout).
    for (int f = 0; f < 40; f++) begin
      while (!m_busy) begin
        idle($urandom_range(0, 23));
        send_byte(rand_byte());
      end
      finish_tx($urandom_range(0, 3));
    end

    // Drop counter saturation.
    do_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h20);
    for (int i = 0; i < 300; i++) send_byte(8'($urandom_range(0, 255)));
    chk("drop_saturate", drop_cnt, 255);
    finish_tx(0);
    chk("saturated_tx", tx_data, 8'h02);

    idle(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
